mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port sharing
// four byte-lane memory banks; one access per cycle, one-cycle read latency.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [14:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [14:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [12:0] bank_addr,
  output logic [3:0]  bank_re,
  output logic [3:0]  bank_we,
  output logic [31:0] bank_wdata,
  input  logic [31:0] bank_rdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic        last_d;
  logic [1:0]  d_off;
  logic [3:0]  d_lanes;
  logic        d_bad;
  logic        d_load;
  logic [31:0] d_raw;
  logic [1:0]  pend_size;
  logic [1:0]  pend_off;
  logic        pend_uns;
  logic        if_addr_unused;

  // Fetches are always whole words, so the byte offset carries no information.
  assign if_addr_unused = ^if_addr[1:0];

  // On contention the port that did not win last time gets the banks.
  assign if_gnt = !rst && if_req && (!d_req || last_d);
  assign d_gnt  = !rst && d_req && !(if_req && last_d);

  assign d_off = d_addr[1:0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    d_lanes = 4'b0000;
    unique case (d_size)
      SIZE_BYTE: d_lanes = 4'b0001 << d_off;
      SIZE_HALF: d_lanes = d_off[0] ? 4'b0000 : (4'b0011 << d_off);
      SIZE_WORD: d_lanes = (d_off == 2'b00) ? 4'b1111 : 4'b0000;
      default:   d_lanes = 4'b0000;
    endcase
  end

  // An empty lane mask marks a misaligned or illegal-size request.
  assign d_bad  = (d_lanes == 4'b0000);
  assign d_load = d_gnt && !d_we && !d_bad;

  assign bank_addr = if_gnt ? if_addr[14:2] : d_addr[14:2];
  assign bank_re   = if_gnt ? 4'b1111 : (d_load ? d_lanes : 4'b0000);
  assign bank_we   = (d_gnt && d_we) ? d_lanes : 4'b0000;

  // Replicating the store data puts it on every lane it could target; bank_we picks.
  always_comb begin
    bank_wdata = d_wdata;
    unique case (d_size)
      SIZE_BYTE: bank_wdata = {4{d_wdata[7:0]}};
      SIZE_HALF: bank_wdata = {2{d_wdata[15:0]}};
      default:   bank_wdata = d_wdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d    <= 1'b1;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= 32'h0;
      d_raw     <= 32'h0;
      pend_size <= SIZE_BYTE;
      pend_off  <= 2'b00;
      pend_uns  <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_load;
      d_err     <= d_gnt && d_bad;
      if (if_gnt || d_gnt) last_d <= d_gnt;
      if (if_gnt) if_rdata <= bank_rdata;
      if (d_load) begin
        d_raw     <= bank_rdata;
        pend_size <= d_size;
        pend_off  <= d_off;
        pend_uns  <= d_unsigned;
      end
    end
  end

  // Load data is extracted from the captured word using the tracked size and offset.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  assign sel_byte = d_raw[{pend_off, 3'b000} +: 8];
  assign sel_half = d_raw[{pend_off[1], 4'b0000} +: 16];

  always_comb begin
    d_rdata = d_raw;
    unique case (pend_size)
      SIZE_BYTE: d_rdata = {{24{!pend_uns && sel_byte[7]}}, sel_byte};
      SIZE_HALF: d_rdata = {{16{!pend_uns && sel_half[15]}}, sel_half};
      default:   d_rdata = d_raw;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected grants and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [14:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [14:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [12:0] bank_addr;
  logic [3:0]  bank_re, bank_we;
  logic [31:0] bank_wdata, bank_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .bank_addr(bank_addr), .bank_re(bank_re), .bank_we(bank_we),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  // Bank model: accesses resolve at the negedge of the access cycle.
  logic [7:0] mem [4][8192];
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bank_we[k]) mem[k][bank_addr] = bank_wdata[8*k +: 8];
      if (bank_re[k]) bank_rdata[8*k +: 8] = mem[k][bank_addr];
    end
  end

  typedef struct {
    logic        port;
    logic [12:0] addr;
    logic [3:0]  re;
    logic [3:0]  we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] exp_if_last = 32'h0;
  logic [31:0] exp_d_last  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  task automatic take_rsp(input int kind, input logic [31:0] data);
    rsp_t r;
    if (rq.size() == 0) begin
      unexpected($sformatf("rsp_kind%0d", kind));
    end else begin
      r = rq.pop_front();
      check("rsp_kind", kind, r.kind);
      if (kind != 2) check("rsp_data", data, r.data);
      if (r.kind == 0) exp_if_last = r.data;
      if (r.kind == 1) exp_d_last = r.data;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    gnt_t g;
    if (rst) begin
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_rvalid", {if_rvalid, d_rvalid, d_err}, 0);
      check("rst_bank_en", {bank_re, bank_we}, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      exp_if_last = 32'h0;
      exp_d_last  = 32'h0;
    end else begin
      if (if_gnt || d_gnt) begin
        check("gnt_exclusive", if_gnt & d_gnt, 0);
        if (gq.size() == 0) begin
          unexpected("gnt");
        end else begin
          g = gq.pop_front();
          check("gnt_port_d", d_gnt, g.port);
          check("bank_addr", bank_addr, g.addr);
          check("bank_re", bank_re, g.re);
          check("bank_we", bank_we, g.we);
          check("bank_wdata", bank_wdata & lane_mask(g.we), g.wdata & lane_mask(g.we));
        end
      end
      if (if_rvalid) take_rsp(0, if_rdata);
      else check("if_rdata_hold", if_rdata, exp_if_last);
      if (d_rvalid) take_rsp(1, d_rdata);
      else check("d_rdata_hold", d_rdata, exp_d_last);
      if (d_err) take_rsp(2, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [14:0] a, input logic [31:0] exp_rd);
    gnt_t g;
    rsp_t r;
    if_req = 1'b1; d_req = 1'b0; if_addr = a;
    g = '{1'b0, a[14:2], 4'b1111, 4'b0000, 32'h0};
    r = '{0, exp_rd};
    gq.push_back(g);
    rq.push_back(r);
    step();
    if_req = 1'b0;
  endtask

  // kind: 1 load response, 2 error pulse, -1 no response (store)
  task automatic dacc(input logic we, input logic [1:0] size, input logic uns,
                      input logic [14:0] a, input logic [31:0] wd,
                      input logic [3:0] exp_re, input logic [3:0] exp_we,
                      input logic [31:0] exp_wd, input int kind,
                      input logic [31:0] exp_rd);
    gnt_t g;
    rsp_t r;
    if_req = 1'b0; d_req = 1'b1;
    d_we = we; d_size = size; d_unsigned = uns; d_addr = a; d_wdata = wd;
    g = '{1'b1, a[14:2], exp_re, exp_we, exp_wd};
    gq.push_back(g);
    if (kind >= 0) begin
      r = '{kind, exp_rd};
      rq.push_back(r);
    end
    step();
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    if_addr = '0; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0;
    d_addr = '0; d_wdata = '0;
    mem[0][13'h010] = 8'hEF; mem[1][13'h010] = 8'hBE;
    mem[2][13'h010] = 8'hAD; mem[3][13'h010] = 8'hDE;
    mem[0][13'h020] = 8'h78; mem[1][13'h020] = 8'h56;
    mem[2][13'h020] = 8'h34; mem[3][13'h020] = 8'h12;
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;

    // Loads, stores and fetches back to back on every cycle
    fetch(15'h0040, 32'hDEADBEEF);
    dacc(0, 2'b00, 0, 15'h0043, 32'h0, 4'b1000, 4'b0000, 32'h0, 1, 32'hFFFFFFDE);
    dacc(0, 2'b01, 1, 15'h0042, 32'h0, 4'b1100, 4'b0000, 32'h0, 1, 32'h0000DEAD);
    dacc(1, 2'b00, 0, 15'h0041, 32'h0000005A, 4'b0000, 4'b0010, 32'h00005A00, -1, 32'h0);
    dacc(0, 2'b10, 0, 15'h0040, 32'h0, 4'b1111, 4'b0000, 32'h0, 1, 32'hDEAD5AEF);
    dacc(0, 2'b01, 0, 15'h0042, 32'h0, 4'b1100, 4'b0000, 32'h0, 1, 32'hFFFFDEAD);
    dacc(0, 2'b01, 0, 15'h0040, 32'h0, 4'b0011, 4'b0000, 32'h0, 1, 32'h00005AEF);
    dacc(1, 2'b01, 0, 15'h0082, 32'h0000ABCD, 4'b0000, 4'b1100, 32'hABCD0000, -1, 32'h0);
    dacc(0, 2'b10, 0, 15'h0080, 32'h0, 4'b1111, 4'b0000, 32'h0, 1, 32'hABCD5678);
    dacc(0, 2'b00, 0, 15'h0082, 32'h0, 4'b0100, 4'b0000, 32'h0, 1, 32'hFFFFFFCD);
    dacc(1, 2'b10, 0, 15'h0084, 32'hCAFEF00D, 4'b0000, 4'b1111, 32'hCAFEF00D, -1, 32'h0);
    dacc(0, 2'b00, 1, 15'h0087, 32'h0, 4'b1000, 4'b0000, 32'h0, 1, 32'h000000CA);
    dacc(0, 2'b00, 0, 15'h0085, 32'h0, 4'b0010, 4'b0000, 32'h0, 1, 32'hFFFFFFF0);
    fetch(15'h0086, 32'hCAFEF00D);

    // Misaligned and illegal-size requests: granted, no bank enables, error pulse
    dacc(0, 2'b10, 0, 15'h0042, 32'h0, 4'b0000, 4'b0000, 32'h0, 2, 32'h0);
    dacc(0, 2'b11, 0, 15'h0040, 32'h0, 4'b0000, 4'b0000, 32'h0, 2, 32'h0);
    dacc(1, 2'b01, 0, 15'h0041, 32'h0000FFFF, 4'b0000, 4'b0000, 32'h0, 2, 32'h0);
    repeat (2) step();

    // Fetch wins last, then reset lands in the middle of another fetch grant
    fetch(15'h0040, 32'hDEAD5AEF);
    begin
      gnt_t g;
      if_req = 1'b1; if_addr = 15'h0040;
      g = '{1'b0, 13'h010, 4'b1111, 4'b0000, 32'h0};
      gq.push_back(g);
      @(negedge clk);
      #1;
      rst = 1'b1;
      if_req = 1'b0;
    end
    repeat (2) step();
    rst = 1'b0;

    // Contention right after reset: F, D, F, D
    if_req = 1'b1; if_addr = 15'h0080;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 15'h0084;
    for (int i = 0; i < 4; i++) begin
      gnt_t g;
      rsp_t r;
      if (i % 2 == 0) begin
        g = '{1'b0, 13'h020, 4'b1111, 4'b0000, 32'h0};
        r = '{0, 32'hABCD5678};
      end else begin
        g = '{1'b1, 13'h021, 4'b1111, 4'b0000, 32'h0};
        r = '{1, 32'hCAFEF00D};
      end
      gq.push_back(g);
      rq.push_back(r);
    end
    repeat (4) step();
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    check("gnt_queue_drained", gq.size(), 0);
    check("rsp_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
